iiitb_rc_chk: RTL and testbench

- Receive-side companion to the 4-bit ring counter: consumes the rotating one-hot ring word and decodes it into a binary position.
- Checks that every sampled word is the legal successor of the previous one and locks after a run of good steps.
- Flags and counts sequence errors.
- Sits downstream of the ring counter output, or on any link carrying ring-coded state.

---
 rtl/iiitb_rc_chk.sv | 154 +++++++++++++++
 tb/tb_iiitb_rc_chk.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_rc_chk.sv
// Ring-code receive checker: decodes a one-hot ring word to a binary position and tracks its rotation.
// Optional sticky error flag with err_clr: define IIITB_RC_CHK_STICKY_ERR_EN.
module iiitb_rc_chk #(
    parameter int WIDTH      = 4,
    parameter int SHIFT_LEFT = 1,
    parameter int LOCK_CNT   = 3,
    parameter int ERR_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           ring_in,
    input  logic                       err_clr,
    output logic [$clog2(WIDTH)-1:0]   pos,
    output logic                       pos_valid,
    output logic                       locked,
    output logic                       err_pulse,
    output logic                       err_flag,
    output logic [ERR_W-1:0]           err_cnt
);
    localparam int PW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic               pos_valid_q, pos_valid_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               err_flag_q, err_flag_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]   exp_word;
    logic [PW-1:0]      idx;
    logic [4:0]         cnt_inc;
    logic               oh, good;

    always_comb begin
        if (SHIFT_LEFT != 0) exp_word = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
        else                 exp_word = {prev_q[0], prev_q[WIDTH-1:1]};
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (ring_in[i]) idx = i[PW-1:0];
    end

    assign oh      = $onehot(ring_in);
    assign good    = oh && (ring_in == exp_word);
    assign cnt_inc = {1'b0, good_cnt_q} + 5'd1;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (in_valid) begin
            pos_valid_d = oh;
            if (oh) begin
                pos_d  = idx;
                prev_d = ring_in;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (oh) begin
                        state_d    = S_TRACK;
                        good_cnt_d = '0;
                    end
                end
                S_TRACK: begin
                    if (good) begin
                        if (cnt_inc == 5'(LOCK_CNT)) begin
                            state_d    = S_LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = cnt_inc[3:0];
                        end
                    end else begin
                        // a legal word out of order re-anchors the run; garbage drops back to IDLE
                        good_cnt_d = '0;
                        if (!oh) state_d = S_IDLE;
                    end
                end
                S_LOCKED: begin
                    if (!good) begin
                        state_d     = S_ERR;
                        err_pulse_d = 1'b1;
                    end
                end
                S_ERR: begin
                    if (oh) begin
                        state_d    = S_TRACK;
                        good_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (err_pulse_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        end
        locked_d = (state_d == S_LOCKED);
`ifdef IIITB_RC_CHK_STICKY_ERR_EN
        // a new error beats a simultaneous clear
        if (err_pulse_d)  err_flag_d = 1'b1;
        else if (err_clr) err_flag_d = 1'b0;
        else              err_flag_d = err_flag_q;
`else
        err_flag_d = (state_d == S_ERR);
`endif
    end

`ifndef IIITB_RC_CHK_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_iiitb_rc_chk.sv
// Bench for iiitb_rc_chk (WIDTH=4, left rotate, LOCK_CNT=3, ERR_W=8): position-based model plus directed literals.
module tb_iiitb_rc_chk;
    localparam int W = 4;
    localparam int LOCK = 3;
    localparam int CMAX = 255;
    localparam int M_IDLE = 0, M_TRACK = 1, M_LOCKED = 2, M_ERR = 3;

    logic         clk = 1'b0;
    logic         reset, in_valid, err_clr;
    logic [W-1:0] ring_in;
    logic [1:0]   pos;
    logic         pos_valid, locked, err_pulse, err_flag;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    iiitb_rc_chk #(.WIDTH(W), .SHIFT_LEFT(1), .LOCK_CNT(LOCK), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ring_in(ring_in), .err_clr(err_clr),
        .pos(pos), .pos_valid(pos_valid), .locked(locked), .err_pulse(err_pulse),
        .err_flag(err_flag), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // model tracks the ring as a position index (-1 = nothing seen yet); a good step is index+1 mod W
    typedef struct {
        int mode; int run; int prev; int pos;
        bit pv; bit lock; bit pulse; bit flag; int err;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode = M_IDLE; r.run = 0; r.prev = -1; r.pos = 0;
        r.pv = 0; r.lock = 0; r.pulse = 0; r.flag = 0; r.err = 0;
        return r;
    endfunction

    function automatic model_t model_next(model_t s, logic v, logic [W-1:0] w, logic clr);
        model_t n = s;
        bit oh, good;
        int idx;
        n.pulse = 0;
        if (v) begin
            oh   = ($countones(w) == 1);
            idx  = oh ? $clog2(w) : -1;
            good = oh && (s.prev >= 0) && (idx == (s.prev + 1) % W);
            case (s.mode)
                M_IDLE:   if (oh) begin n.mode = M_TRACK; n.run = 0; end
                M_TRACK:  if (good) begin
                              n.run = s.run + 1;
                              if (n.run == LOCK) n.mode = M_LOCKED;
                          end else if (oh) n.run = 0;
                          else n.mode = M_IDLE;
                M_LOCKED: if (!good) begin n.mode = M_ERR; n.pulse = 1; end
                default:  if (oh) begin n.mode = M_TRACK; n.run = 0; end
                          else n.pulse = 1;
            endcase
            if (n.pulse && n.err < CMAX) n.err = n.err + 1;
            n.pv = oh;
            if (oh) begin n.prev = idx; n.pos = idx; end
        end
`ifdef IIITB_RC_CHK_STICKY_ERR_EN
        if (n.pulse) n.flag = 1;
        else if (clr) n.flag = 0;
`else
        n.flag = (n.mode == M_ERR);
`endif
        n.lock = (n.mode == M_LOCKED);
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= model_next(m, in_valid, ring_in, err_clr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_pos", 32'(pos), 32'(m.pos));
        chk("m_pos_valid", 32'(pos_valid), 32'(m.pv));
        chk("m_locked", 32'(locked), 32'(m.lock));
        chk("m_err_pulse", 32'(err_pulse), 32'(m.pulse));
        chk("m_err_flag", 32'(err_flag), 32'(m.flag));
        chk("m_err_cnt", 32'(err_cnt), 32'(m.err));
    end

    task automatic step(input logic v, input logic [W-1:0] w, input logic clr);
        @(negedge clk);
        in_valid = v; ring_in = w; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; err_clr = 0; reset = 0;
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        reset = 0; in_valid = 0; ring_in = '0; err_clr = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pos_valid", 32'(pos_valid), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        reset = 1;

        // lock-in
        step(1, 4'b0010, 0); chk("t1_pos1", 32'(pos), 1);
        step(1, 4'b0100, 0); chk("t1_pos2", 32'(pos), 2);
        step(1, 4'b1000, 0); chk("t1_pos3", 32'(pos), 3); chk("t1_not_locked", 32'(locked), 0);
        step(1, 4'b0001, 0); chk("t1_pos0", 32'(pos), 0); chk("t1_locked", 32'(locked), 1);
        chk("t1_err_cnt", 32'(err_cnt), 0);

        // wrap through MSB->LSB already crossed; keep going
        step(1, 4'b0010, 0); chk("t2_locked", 32'(locked), 1); chk("t2_pulse", 32'(err_pulse), 0);
        step(1, 4'b0100, 0);

        // skip error (0100 -> 0001)
        step(1, 4'b0001, 0);
        chk("t3_pulse", 32'(err_pulse), 1); chk("t3_err_cnt", 32'(err_cnt), 1);
        chk("t3_locked", 32'(locked), 0); chk("t3_flag", 32'(err_flag), 1);
        step(0, 4'b0001, 0); chk("t3_pulse_once", 32'(err_pulse), 0);
        step(1, 4'b0010, 0);
        step(1, 4'b0100, 0);
        step(1, 4'b1000, 0); chk("t3_not_yet", 32'(locked), 0);
        step(1, 4'b0001, 0); chk("t3_relock", 32'(locked), 1);

        // flag after relock, clear, and error with clear held
`ifdef IIITB_RC_CHK_STICKY_ERR_EN
        chk("t6_sticky", 32'(err_flag), 1);
        step(0, 4'b0001, 1); chk("t6_cleared", 32'(err_flag), 0);
`else
        chk("t6_flag_lock", 32'(err_flag), 0);
        step(0, 4'b0001, 1); chk("t6_flag_idle", 32'(err_flag), 0);
`endif
        step(1, 4'b0100, 1);
        chk("t6_set_wins", 32'(err_flag), 1); chk("t6_err_cnt", 32'(err_cnt), 2);
        step(0, 4'b0100, 1);
`ifdef IIITB_RC_CHK_STICKY_ERR_EN
        chk("t6_clr_in_err", 32'(err_flag), 0);
`else
        chk("t6_clr_ignored", 32'(err_flag), 1);
`endif
        step(0, 4'b0100, 0);

        // illegal codes after a fresh lock
        do_reset();
        step(1, 4'b0010, 0); step(1, 4'b0100, 0); step(1, 4'b1000, 0);
        step(1, 4'b0001, 0); step(1, 4'b0010, 0);
        chk("t4_locked", 32'(locked), 1); chk("t4_pos", 32'(pos), 1);
        step(1, 4'b0000, 0);
        chk("t4_zero_pulse", 32'(err_pulse), 1); chk("t4_zero_pv", 32'(pos_valid), 0);
        chk("t4_zero_pos", 32'(pos), 1); chk("t4_zero_cnt", 32'(err_cnt), 1);
        step(1, 4'b0110, 0);
        chk("t4_multi_pulse", 32'(err_pulse), 1); chk("t4_multi_cnt", 32'(err_cnt), 2);
        chk("t4_multi_pos", 32'(pos), 1);
        step(1, 4'b1000, 0);
        chk("t4_track_pulse", 32'(err_pulse), 0); chk("t4_track_cnt", 32'(err_cnt), 2);
        chk("t4_track_pos", 32'(pos), 3); chk("t4_track_pv", 32'(pos_valid), 1);
        step(1, 4'b0001, 0); step(1, 4'b0010, 0); step(1, 4'b0100, 0);
        chk("t4_relock", 32'(locked), 1);

        // hold, then asynchronous reset between edges
        repeat (5) step(0, 4'b1111, 0);
        chk("t5_hold_locked", 32'(locked), 1); chk("t5_hold_pos", 32'(pos), 2);
        chk("t5_hold_cnt", 32'(err_cnt), 2); chk("t5_hold_pv", 32'(pos_valid), 1);
        @(posedge clk);
        #3 reset = 0;
        #1;
        chk("t5_rst_pos", 32'(pos), 0); chk("t5_rst_pv", 32'(pos_valid), 0);
        chk("t5_rst_locked", 32'(locked), 0); chk("t5_rst_cnt", 32'(err_cnt), 0);
        chk("t5_rst_flag", 32'(err_flag), 0); chk("t5_rst_pulse", 32'(err_pulse), 0);
        @(negedge clk);
        reset = 1;

        // IDLE ignores garbage, then saturate the error counter
        step(1, 4'b0011, 0);
        chk("t7_idle_pulse", 32'(err_pulse), 0); chk("t7_idle_pv", 32'(pos_valid), 0);
        step(1, 4'b0001, 0); step(1, 4'b0010, 0); step(1, 4'b0100, 0); step(1, 4'b1000, 0);
        chk("t7_locked", 32'(locked), 1);
        repeat (260) step(1, 4'b0000, 0);
        chk("t7_sat_cnt", 32'(err_cnt), 255); chk("t7_sat_pulse", 32'(err_pulse), 1);
        step(0, 4'b0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
